// File: rtl/debounce_edge_if.sv
// Bundle between a raw level source and the debounce/edge stage.
// The master drives the raw level; the slave returns the clean level, pulses and rise count.
interface debounce_edge_if #(
  parameter int unsigned CNT_W = 8
);
  logic             d;
  logic             q;
  logic             rise;
  logic             fall;
  logic             busy;
  logic [CNT_W-1:0] rise_count;

  modport master (output d, input q, rise, fall, busy, rise_count);
  modport slave  (input d, output q, rise, fall, busy, rise_count);
endinterface

// File: rtl/debounce_edge.sv
// Two-flop synchroniser followed by a four-state debounce FSM that produces a clean
// level, single-cycle rise/fall pulses and a wrapping rising-edge counter.
module debounce_edge #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  debounce_edge_if.slave   bus
);

  typedef enum logic [1:0] {
    LOW        = 2'b00,
    CHECK_HIGH = 2'b01,
    HIGH       = 2'b10,
    CHECK_LOW  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_r;
  logic             s2_r;
  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             q_r;
  logic             q_s;
  logic             rise_r;
  logic             rise_s;
  logic             fall_r;
  logic             fall_s;
  logic             busy_r;
  logic             busy_s;
  logic [CNT_W-1:0] rise_count_r;
  logic [CNT_W-1:0] rise_count_s;

  // Synchroniser, state register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r         <= 1'b0;
      s2_r         <= 1'b0;
      state_r      <= LOW;
      cnt_r        <= CNT_ZERO;
      q_r          <= 1'b0;
      rise_r       <= 1'b0;
      fall_r       <= 1'b0;
      busy_r       <= 1'b0;
      rise_count_r <= CNT_ZERO;
    end else begin
      s1_r         <= bus.d;
      s2_r         <= s1_r;
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      q_r          <= q_s;
      rise_r       <= rise_s;
      fall_r       <= fall_s;
      busy_r       <= busy_s;
      rise_count_r <= rise_count_s;
    end
  end

  // Next-state, stability count and pulse generation.
  always_comb begin
    state_s      = state_r;
    cnt_s        = CNT_ZERO;
    q_s          = q_r;
    rise_s       = 1'b0;
    fall_s       = 1'b0;
    rise_count_s = rise_count_r;
    case (state_r)
      LOW: begin
        if (s2_r) begin
          state_s = CHECK_HIGH;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = LOW;
        end
      end
      CHECK_HIGH: begin
        if (!s2_r) begin
          state_s = LOW;
        end else if (cnt_r == CNT_LAST) begin
          state_s      = HIGH;
          q_s          = 1'b1;
          rise_s       = 1'b1;
          rise_count_s = rise_count_r + CNT_ONE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2_r) begin
          state_s = CHECK_LOW;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = HIGH;
        end
      end
      CHECK_LOW: begin
        if (s2_r) begin
          state_s = HIGH;
        end else if (cnt_r == CNT_LAST) begin
          state_s = LOW;
          q_s     = 1'b0;
          fall_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = LOW;
        q_s     = 1'b0;
      end
    endcase
    // busy is registered alongside the state so it tracks state_r with no added latency
    busy_s = (state_s == CHECK_HIGH) || (state_s == CHECK_LOW);
  end

  assign bus.q          = q_r;
  assign bus.rise       = rise_r;
  assign bus.fall       = fall_r;
  assign bus.busy       = busy_r;
  assign bus.rise_count = rise_count_r;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge: stimulus pushes expected pulses into a scoreboard
// queue, a monitor pops and compares each rise/fall pulse the DUT produces.
module tb_debounce_edge;

  localparam int STABLE = 4;

  typedef struct {
    bit         is_rise;
    int         edge_no;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   ecount;
  int   checks;
  int   fails;
  int   exp_rises;
  int   exp_falls;
  int   seen_rises;
  int   seen_falls;
  exp_t sb[$];

  debounce_edge_if #(.CNT_W(8)) bus ();

  debounce_edge #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (bus.rise === 1'b1 || bus.fall === 1'b1) begin
      chk("rise_fall_excl", {31'd0, bus.rise & bus.fall}, 32'd0);
      if (bus.rise === 1'b1) seen_rises++;
      if (bus.fall === 1'b1) seen_falls++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {31'd0, bus.rise}, {31'd0, ~bus.rise});
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {31'd0, bus.rise}, {31'd0, e.is_rise});
        chk("pulse_edge", ecount, e.edge_no);
        chk("pulse_q", {31'd0, bus.q}, {31'd0, e.is_rise});
        chk("pulse_count", {24'd0, bus.rise_count}, {24'd0, e.cnt});
      end
    end
  end

  task automatic set_d(input logic v, output int k);
    @(negedge clk);
    bus.d = v;
    k = ecount + 1;
  endtask

  task automatic push(input bit is_rise, input int edge_no, input int cnt);
    exp_t e;
    e.is_rise = is_rise;
    e.edge_no = edge_no;
    e.cnt     = 8'(cnt);
    sb.push_back(e);
    if (is_rise) exp_rises++;
    else exp_falls++;
  endtask

  task automatic check_window(input int k, input logic lvl);
    int e;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      e = ecount;
      chk("busy_window", {31'd0, bus.busy}, {31'd0, (e >= k + 2 && e <= k + 4)});
      chk("q_window", {31'd0, bus.q}, {31'd0, (e >= k + STABLE + 1) ? lvl : ~lvl});
    end
  endtask

  initial begin
    int k;
    int k2;
    int busy_n;
    int q_hi;
    ecount = 0;
    checks = 0;
    fails = 0;
    exp_rises = 0;
    exp_falls = 0;
    seen_rises = 0;
    seen_falls = 0;
    reset = 1'b1;
    bus.d = 1'b0;

    // reset held 2 cycles, then 5 idle cycles with everything quiet
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_q", {31'd0, bus.q}, 32'd0);
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_pulses", {30'd0, bus.rise, bus.fall}, 32'd0);
      chk("reset_count", {24'd0, bus.rise_count}, 32'd0);
    end

    // clean rise then clean fall
    set_d(1'b1, k);
    push(1'b1, k + STABLE + 1, 1);
    check_window(k, 1'b1);
    set_d(1'b0, k);
    push(1'b0, k + STABLE + 1, 1);
    check_window(k, 1'b0);
    repeat (3) @(negedge clk);

    // 3-cycle glitch is rejected
    set_d(1'b1, k);
    busy_n = 0;
    q_hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) bus.d = 1'b0;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.q !== 1'b0) q_hi++;
    end
    chk("glitch_busy_cycles", busy_n, 3);
    chk("glitch_q_high", q_hi, 0);
    chk("glitch_count", {24'd0, bus.rise_count}, 32'd1);

    // 4-cycle pulse is accepted
    set_d(1'b1, k);
    push(1'b1, k + STABLE + 1, 2);
    repeat (3) @(negedge clk);
    set_d(1'b0, k2);
    push(1'b0, k2 + STABLE + 1, 2);
    repeat (12) @(negedge clk);

    // restart: 1 for 2 cycles, 0 for 1, then held high
    set_d(1'b1, k);
    @(negedge clk);
    set_d(1'b0, k);
    set_d(1'b1, k);
    push(1'b1, k + STABLE + 1, 3);
    repeat (10) @(negedge clk);
    set_d(1'b0, k);
    push(1'b0, k + STABLE + 1, 3);
    repeat (10) @(negedge clk);

    // reset in the middle of CHECK_HIGH
    set_d(1'b1, k);
    repeat (3) @(negedge clk);
    chk("midcheck_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_q", {31'd0, bus.q}, 32'd0);
    chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
    chk("midreset_pulses", {30'd0, bus.rise, bus.fall}, 32'd0);
    chk("midreset_count", {24'd0, bus.rise_count}, 32'd0);
    reset = 1'b0;
    k = ecount + 1;
    push(1'b1, k + STABLE + 1, 1);
    repeat (10) @(negedge clk);
    chk("post_reset_q", {31'd0, bus.q}, 32'd1);
    set_d(1'b0, k);
    push(1'b0, k + STABLE + 1, 1);
    repeat (10) @(negedge clk);

    // counter wrap over 256 rises
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      set_d(1'b1, k);
      push(1'b1, k + STABLE + 1, n);
      repeat (5) @(negedge clk);
      set_d(1'b0, k);
      push(1'b0, k + STABLE + 1, n);
      repeat (5) @(negedge clk);
      if (n == 255) chk("wrap_255", {24'd0, bus.rise_count}, 32'd255);
      if (n == 256) chk("wrap_0", {24'd0, bus.rise_count}, 32'd0);
    end
    repeat (12) @(negedge clk);

    chk("pending_expected", sb.size(), 0);
    chk("total_rises", seen_rises, exp_rises);
    chk("total_falls", seen_falls, exp_falls);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
